// File: rtl/alu_pkg.sv
// Shared definitions for the ALU self-test: opcodes, LFSR taps, FSM encoding, golden model.
// ALU_BIST_SLT_EN adds signed set-less-than (opcode 111) to the exercised op sequence.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

`ifdef ALU_BIST_SLT_EN
  localparam int OP_SEQ_LEN = 5;
`else
  localparam int OP_SEQ_LEN = 4;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN_A,
    ST_GEN_B,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Right-shifting Galois form: feedback applied when the bit shifted out is 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [2:0] op_at(input logic [2:0] idx);
    logic [2:0] op;
    case (idx)
      3'd0:    op = OP_AND;
      3'd1:    op = OP_OR;
      3'd2:    op = OP_ADD;
      3'd3:    op = OP_SUB;
`ifdef ALU_BIST_SLT_EN
      3'd4:    op = OP_SLT;
`endif
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] alu_expect(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
    logic [31:0] z;
    case (op)
      OP_AND:  z = a & b;
      OP_OR:   z = a | b;
      OP_ADD:  z = a + b;
      OP_SUB:  z = a - b;
`ifdef ALU_BIST_SLT_EN
      OP_SLT:  z = {31'b0, $signed(a) < $signed(b)};
`endif
      default: z = 32'h0;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// 32-bit Galois LFSR operand source; one step per enabled cycle, reseed has priority.
// Exposes the value the register takes on an enabled step so the caller can latch it in the same edge.
module bist_lfsr32
  import alu_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE12468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        reseed,
  output logic [31:0] state_nxt
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h00000001 : SEED;

  logic [31:0] state_q;
  logic [31:0] state_d;

  assign state_nxt = lfsr_step(state_q);

  always_comb begin
    state_d = state_q;
    if (reseed) begin
      state_d = SEED_EFF;
    end else if (en) begin
      state_d = state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED_EFF;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/alu_bist.sv
// Built-in self-test controller driving a 32-bit ALU with LFSR operands and checking its result.
// One vector costs 3+SETTLE cycles; ALU_BIST_SLT_EN extends the op sequence with signed SLT.
module alu_bist
  import alu_pkg::*;
#(
  parameter int          N_VEC  = 16,
  parameter int          SETTLE = 1,
  parameter logic [31:0] SEED   = 32'hACE12468
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_z,
  input  logic        alu_ex,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] vec_cnt,
  output logic [15:0] fail_cnt
);

  localparam logic [16:0] N_VEC_W   = 17'(N_VEC);
  localparam logic [3:0]  SETTLE_W  = 4'(SETTLE);
  localparam logic [2:0]  LAST_IDX  = 3'(OP_SEQ_LEN - 1);

  state_e      state_q, state_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic [15:0] vec_cnt_q, vec_cnt_d;
  logic [15:0] fail_cnt_q, fail_cnt_d;
  logic [3:0]  settle_q, settle_d;
  logic [2:0]  op_idx_q, op_idx_d;

  logic        lfsr_en;
  logic        lfsr_reseed;
  logic [31:0] lfsr_nxt;
  logic [31:0] exp_z;
  logic        exp_ex;
  logic        mismatch;

  bist_lfsr32 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (reset),
    .en       (lfsr_en),
    .reseed   (lfsr_reseed),
    .state_nxt(lfsr_nxt)
  );

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    vec_cnt_d   = vec_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    settle_d    = settle_q;
    op_idx_d    = op_idx_q;
    lfsr_en     = 1'b0;
    lfsr_reseed = 1'b0;

    exp_z    = alu_expect(alu_a_q, alu_b_q, alu_op_q);
    exp_ex   = (exp_z == 32'h0);
    mismatch = (alu_z != exp_z) || (alu_ex != exp_ex);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_GEN_A;
          vec_cnt_d   = 16'h0;
          fail_cnt_d  = 16'h0;
          op_idx_d    = 3'd0;
          lfsr_reseed = 1'b1;
        end
      end
      ST_GEN_A: begin
        alu_a_d = lfsr_nxt;
        lfsr_en = 1'b1;
        state_d = ST_GEN_B;
      end
      ST_GEN_B: begin
        alu_b_d  = lfsr_nxt;
        lfsr_en  = 1'b1;
        alu_op_d = op_at(op_idx_q);
        settle_d = SETTLE_W;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q <= 4'd1) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      ST_CHECK: begin
        vec_cnt_d = vec_cnt_q + 16'd1;
        if (mismatch) begin
          fail_cnt_d = fail_cnt_q + 16'd1;
        end
        op_idx_d = (op_idx_q == LAST_IDX) ? 3'd0 : op_idx_q + 3'd1;
        state_d  = (({1'b0, vec_cnt_q} + 17'd1) < N_VEC_W) ? ST_GEN_A : ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      alu_a_q    <= 32'h0;
      alu_b_q    <= 32'h0;
      alu_op_q   <= OP_AND;
      vec_cnt_q  <= 16'h0;
      fail_cnt_q <= 16'h0;
      settle_q   <= 4'h0;
      op_idx_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      vec_cnt_q  <= vec_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      settle_q   <= settle_d;
      op_idx_q   <= op_idx_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign vec_cnt  = vec_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign pass     = done && (fail_cnt_q == 16'h0);

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: behavioural ALU with injectable faults, three DUT configurations.
module tb_alu_bist;

  logic clk;
  logic reset;
  logic start0, start1, start2;
  int   fault;

  logic [31:0] a0, b0, z0, a1, b1, z1, a2, b2, z2;
  logic [2:0]  op0, op1, op2;
  logic        ex0, ex1, ex2;
  logic        busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
  logic [15:0] vc0, fc0, vc1, fc1, vc2, fc2;

  int checks;
  int failures;

  logic [31:0] a_exp [8];
  logic [31:0] b_exp [8];

  typedef struct {
    int          fault;
    bit          spur;
    logic [15:0] exp_fail;
    bit          exp_pass;
  } run_t;

  run_t tbl [4];

  // 0: correct ALU, 1: ADD result off by one, 2: zero flag inverted
  function automatic logic [32:0] tb_alu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op, input int mode);
    logic [31:0] z;
    logic        ex;
    case (op)
      3'b000:  z = a & b;
      3'b001:  z = a | b;
      3'b010:  z = a + b + ((mode == 1) ? 32'd1 : 32'd0);
      3'b110:  z = a - b;
      3'b111:  z = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: z = 32'h0;
    endcase
    ex = (z == 32'h0);
    if (mode == 2) ex = ~ex;
    return {ex, z};
  endfunction

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [2:0] exp_op(input int k);
    logic [2:0] seq [5];
    seq[0] = 3'b000; seq[1] = 3'b001; seq[2] = 3'b010; seq[3] = 3'b110; seq[4] = 3'b111;
`ifdef ALU_BIST_SLT_EN
    return seq[k % 5];
`else
    return seq[k % 4];
`endif
  endfunction

  assign {ex0, z0} = tb_alu(a0, b0, op0, fault);
  assign {ex1, z1} = tb_alu(a1, b1, op1, fault);
  assign {ex2, z2} = tb_alu(a2, b2, op2, fault);

  alu_bist #(.N_VEC(8), .SETTLE(1)) u0 (
    .clk(clk), .reset(reset), .start(start0),
    .alu_a(a0), .alu_b(b0), .alu_op(op0), .alu_z(z0), .alu_ex(ex0),
    .busy(busy0), .done(done0), .pass(pass0), .vec_cnt(vc0), .fail_cnt(fc0)
  );

  alu_bist #(.N_VEC(8), .SETTLE(3)) u1 (
    .clk(clk), .reset(reset), .start(start1),
    .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_z(z1), .alu_ex(ex1),
    .busy(busy1), .done(done1), .pass(pass1), .vec_cnt(vc1), .fail_cnt(fc1)
  );

  alu_bist #(.N_VEC(8), .SETTLE(1), .SEED(32'h0)) u2 (
    .clk(clk), .reset(reset), .start(start2),
    .alu_a(a2), .alu_b(b2), .alu_op(op2), .alu_z(z2), .alu_ex(ex2),
    .busy(busy2), .done(done2), .pass(pass2), .vec_cnt(vc2), .fail_cnt(fc2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_u0_zero(input string tag);
    chk({tag, "_alu_a"}, a0, 32'h0);
    chk({tag, "_alu_b"}, b0, 32'h0);
    chk({tag, "_alu_op"}, {29'h0, op0}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy0}, 32'h0);
    chk({tag, "_done"}, {31'h0, done0}, 32'h0);
    chk({tag, "_pass"}, {31'h0, pass0}, 32'h0);
    chk({tag, "_vec_cnt"}, {16'h0, vc0}, 32'h0);
    chk({tag, "_fail_cnt"}, {16'h0, fc0}, 32'h0);
  endtask

  // Cycle c is the state after the c-th edge following the start-sampling edge.
  task automatic run_u0(input bit spur, input logic [15:0] ef, input bit ep);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      start0 = spur && (c == 5 || c == 9);
      if (c == 1) chk("busy_c1", {31'h0, busy0}, 32'd1);
      if (c % 4 == 2) chk("alu_a_vec", a0, a_exp[c / 4]);
      if (c % 4 == 3) begin
        chk("alu_b_vec", b0, b_exp[c / 4]);
        chk("alu_op_vec", {29'h0, op0}, {29'h0, exp_op(c / 4)});
      end
      if (c == 32) chk("done_c32", {31'h0, done0}, 32'd0);
      if (c == 33) begin
        chk("done_c33", {31'h0, done0}, 32'd1);
        chk("busy_c33", {31'h0, busy0}, 32'd0);
        chk("vec_cnt_end", {16'h0, vc0}, 32'd8);
        chk("fail_cnt_end", {16'h0, fc0}, {16'h0, ef});
        chk("pass_end", {31'h0, pass0}, {31'h0, ep});
      end
      if (c < 33) tick();
    end
    start0 = 1'b0;
  endtask

  initial begin
    logic [31:0] s;
    checks   = 0;
    failures = 0;
    fault    = 0;
    reset    = 1'b1;
    start0   = 1'b0;
    start1   = 1'b0;
    start2   = 1'b0;

    s = 32'hACE12468;
    for (int k = 0; k < 8; k++) begin
      s = lstep(s);
      a_exp[k] = s;
      s = lstep(s);
      b_exp[k] = s;
    end
    chk("model_a0", a_exp[0], 32'h56709234);
    chk("model_b0", b_exp[0], 32'h2B38491A);

    tbl[0] = '{fault: 0, spur: 1'b0, exp_fail: 16'd0, exp_pass: 1'b1};
    tbl[1] = '{fault: 1, spur: 1'b0, exp_fail: 16'd2, exp_pass: 1'b0};
    tbl[2] = '{fault: 2, spur: 1'b0, exp_fail: 16'd8, exp_pass: 1'b0};
    tbl[3] = '{fault: 0, spur: 1'b1, exp_fail: 16'd0, exp_pass: 1'b1};

    #2;
    chk_u0_zero("rst");
    tick();
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      fault = tbl[i].fault;
      run_u0(tbl[i].spur, tbl[i].exp_fail, tbl[i].exp_pass);
    end
    fault = 0;

    repeat (3) tick();
    chk("done_hold", {31'h0, done0}, 32'd1);
    chk("alu_a_hold", a0, a_exp[7]);
    chk("vec_cnt_hold", {16'h0, vc0}, 32'd8);

    // Reset partway through a run, then confirm a fresh run repeats the stream.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (13) tick();
    chk("busy_c14", {31'h0, busy0}, 32'd1);
    reset = 1'b1;
    #1;
    chk_u0_zero("midrst");
    tick();
    tick();
    reset = 1'b0;
    tick();
    run_u0(1'b0, 16'd0, 1'b1);

    // SETTLE=3: operands held across the settle window, CHECK at cycle 6.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 1; c <= 49; c++) begin
      if (c >= 3 && c <= 6) begin
        chk("s3_alu_a", a1, a_exp[0]);
        chk("s3_alu_b", b1, b_exp[0]);
        chk("s3_alu_op", {29'h0, op1}, 32'd0);
      end
      if (c == 6) chk("s3_vec_c6", {16'h0, vc1}, 32'd0);
      if (c == 7) chk("s3_vec_c7", {16'h0, vc1}, 32'd1);
      if (c == 48) chk("s3_done_c48", {31'h0, done1}, 32'd0);
      if (c == 49) begin
        chk("s3_done_c49", {31'h0, done1}, 32'd1);
        chk("s3_pass", {31'h0, pass1}, 32'd1);
      end
      if (c < 49) tick();
    end

    // SEED=0 is replaced by 1.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (c == 2) chk("seed0_alu_a", a2, 32'h80200003);
      if (c == 3) chk("seed0_alu_b", b2, 32'hC0300002);
      if (c == 33) begin
        chk("seed0_done", {31'h0, done2}, 32'd1);
        chk("seed0_pass", {31'h0, pass2}, 32'd1);
      end
      if (c < 33) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Sequential built-in self-test controller that sits on the operand/opcode side of the 32-bit combinational ALU (yAlu: a, b, op in; z, ex out).
- Generates pseudo-random operand pairs and steps through the ALU opcodes.
- Samples the ALU result after a settle window, compares it against an internal golden model, and reports pass/fail counts.
- Lets the ALU be checked in hardware with no software testbench.

Parameters:
- N_VEC, 16, number of vectors per run (1..65535).
- SETTLE, 1, cycles operands are held before the result is sampled (1..15).
- SEED, 32'hACE12468, LFSR seed; a value of 0 is replaced by 32'h00000001.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a run.
- alu_a  output  32  operand A to the ALU.
- alu_b  output  32  operand B to the ALU.
- alu_op  output  3  opcode to the ALU.
- alu_z  input  32  ALU result.
- alu_ex  input  1  ALU zero flag; expected to be 1 when z == 0.
- busy  output  1  high from GEN_A through the last CHECK.
- done  output  1  high while in DONE.
- pass  output  1  done && fail_cnt == 0.
- vec_cnt  output  16  vectors completed in the current run.
- fail_cnt  output  16  mismatching vectors in the current run.

Behaviour:
- Reset values: alu_a/alu_b = 0, alu_op = 3'b000, busy/done/pass = 0, counters = 0, LFSR = SEED, FSM = IDLE.
- LFSR: 32-bit Galois, taps 32'h80200003 (x^32+x^22+x^2+x+1). Advances one step in GEN_A and one step in GEN_B only.
- FSM states: IDLE, GEN_A, GEN_B, SETTLE, CHECK, DONE.
  - IDLE: start=1 → GEN_A. Counters clear and the LFSR reseeds on that edge.
  - GEN_A: alu_a <= next LFSR value → GEN_B.
  - GEN_B: alu_b <= next LFSR value; alu_op <= op sequence[vec_cnt mod L] → SETTLE with settle counter = SETTLE.
  - SETTLE: decrement the settle counter; at 1 → CHECK.
  - CHECK: register the compare result, increment vec_cnt, increment fail_cnt on mismatch. Then → GEN_A if vec_cnt+1 < N_VEC, else → DONE.
  - DONE: hold all outputs. start=1 → new run (same as from IDLE, reseeded, so the vector stream repeats).
- Op sequence: 000 AND, 001 OR, 010 ADD, 110 SUB, so L = 4.
- Expected result: exp_z = a&b, a|b, a+b (mod 2^32, carry dropped), a-b (two's complement). exp_ex = (exp_z == 0).
- Mismatch: alu_z != exp_z OR alu_ex != exp_ex.
- Stability: alu_a/alu_b/alu_op are registered and stable from the edge leaving GEN_B until the edge leaving CHECK.
- Timing: one vector takes 3+SETTLE cycles. Taking the start-sampling edge as cycle 0, DONE is entered at cycle N_VEC*(3+SETTLE)+1.
- start while busy is ignored.
- Reset mid-run returns to IDLE immediately (asynchronous) with all reset values.
- A start coincident with reset deassertion is honoured only on the next edge.

Optional Feature:
- Macro: ALU_BIST_SLT_EN.
- Defined: opcode 111 (set-less-than, signed: z = {31'b0, $signed(a) < $signed(b)}) is appended to the op sequence, so L = 5 (000, 001, 010, 110, 111).
- Undefined: L = 4 and opcode 111 is never driven.

Decomposition:
- Shared package alu_pkg holds:
  - localparams OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b110, OP_SLT=3'b111.
  - LFSR_TAPS, the state encoding, and the golden-model function alu_expect(a, b, op).
- One sub-module, bist_lfsr32: enable, reseed, state out.
- The FSM, counters and compare stay in alu_bist.

Test Plan:
- Correct ALU, N_VEC=8, SETTLE=1, start at cycle 0 → done rises at cycle 33, vec_cnt=8, fail_cnt=0, pass=1.
- ALU that adds 1 to the ADD result only, N_VEC=8 → fail_cnt=2 (vectors 2 and 6), pass=0. Under ALU_BIST_SLT_EN → fail_cnt=2 (vectors 2 and 7).
- ALU with correct z but inverted ex → fail_cnt=8.
- start pulsed at cycles 5 and 9 during a run → ignored, done still at cycle 33.
- SETTLE=3 → alu_a/alu_b/alu_op unchanged across the 3 settle cycles. For vector 0, CHECK is at cycle 6. done at cycle 8*6+1=49.
- reset asserted at cycle 14 → all outputs 0 that cycle. A restart reproduces the same alu_a/alu_b sequence as the first run; SEED=0 gives first alu_a = LFSR step from 1.
